// File: rtl/ul_read_arb_axis_pkg.sv
// rtl/ul_read_arb_axis_pkg.sv - shared types, constants and round-robin helper for the UL read arbiter
package ul_read_arb_axis_pkg;

    localparam int   UL_PORT_ID_W        = 1;
    localparam logic RR_RESET_LAST       = 1'b1;
    localparam int   MAX_OUTSTANDING_DEF = 8;

    typedef logic [UL_PORT_ID_W-1:0] ul_port_id_t;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // With both requesters valid the one that did not win last time goes next.
    function automatic ul_port_id_t rr_pick(input logic s0_v, input logic s1_v,
                                            input ul_port_id_t last);
        ul_port_id_t pick;
        pick = ~last;
        if (s0_v && !s1_v)
            pick = 1'b0;
        else if (s1_v && !s0_v)
            pick = 1'b1;
        return pick;
    endfunction

endpackage

// File: rtl/ul_read_arb_axis_tag_fifo.sv
// rtl/ul_read_arb_axis_tag_fifo.sv - register FIFO of requester ids, one entry per read in flight
module ul_rd_tag_fifo
    import ul_read_arb_axis_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  ul_port_id_t              i_din,
    input  logic                     i_pop,
    output ul_port_id_t              o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ul_port_id_t     r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= i_din;
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push_ok && !w_pop_ok)
                r_count <= r_count + CW'(1);
            else if (!w_push_ok && w_pop_ok)
                r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/ul_read_arb_axis.sv
// rtl/ul_read_arb_axis.sv - two-requester UL read arbiter: round-robin AR grant, in-order R steering
module ul_read_arb_axis
    import ul_read_arb_axis_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int NBITS           = 4,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                              s_ul_clk,
    input  logic                              s_ul_rst,

    input  logic [NBITS-1:0]                  s0_ul_araddr,
    input  logic                              s0_ul_arvalid,
    output logic                              s0_ul_arready,
    output logic [DATA_WIDTH-1:0]             s0_ul_rdata,
    output logic                              s0_ul_rvalid,
    input  logic                              s0_ul_rready,

    input  logic [NBITS-1:0]                  s1_ul_araddr,
    input  logic                              s1_ul_arvalid,
    output logic                              s1_ul_arready,
    output logic [DATA_WIDTH-1:0]             s1_ul_rdata,
    output logic                              s1_ul_rvalid,
    input  logic                              s1_ul_rready,

    output logic [NBITS-1:0]                  m_ul_araddr,
    output logic                              m_ul_arvalid,
    input  logic                              m_ul_arready,
    input  logic [DATA_WIDTH-1:0]             m_ul_rdata,
    input  logic                              m_ul_rvalid,
    output logic                              m_ul_rready,

    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding
);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    ul_port_id_t r_lock_id;
    ul_port_id_t w_lock_id_nxt;
    ul_port_id_t r_last_grant;
    ul_port_id_t w_last_grant_nxt;

    ul_port_id_t w_grant;
    ul_port_id_t w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_ar_accept;
    logic        w_r_pop;

    // A stalled address is held on the locked requester until the slave takes it.
    always_comb begin
        w_grant = rr_pick(s0_ul_arvalid, s1_ul_arvalid, r_last_grant);
        if (r_state == ARB_LOCKED)
            w_grant = r_lock_id;
    end

    assign m_ul_arvalid  = !s_ul_rst && !w_full &&
                           ((r_state == ARB_LOCKED) || s0_ul_arvalid || s1_ul_arvalid);
    assign m_ul_araddr   = (w_grant == 1'b1) ? s1_ul_araddr : s0_ul_araddr;
    assign w_ar_accept   = m_ul_arvalid && m_ul_arready;
    assign s0_ul_arready = w_ar_accept && (w_grant == 1'b0);
    assign s1_ul_arready = w_ar_accept && (w_grant == 1'b1);

    always_comb begin
        w_state_nxt      = r_state;
        w_lock_id_nxt    = r_lock_id;
        w_last_grant_nxt = r_last_grant;
        if (w_ar_accept) begin
            w_state_nxt      = ARB_OPEN;
            w_last_grant_nxt = w_grant;
        end else if (m_ul_arvalid) begin
            w_state_nxt   = ARB_LOCKED;
            w_lock_id_nxt = w_grant;
        end
    end

    always_ff @(posedge s_ul_clk) begin
        if (s_ul_rst) begin
            r_state      <= ARB_OPEN;
            r_lock_id    <= '0;
            r_last_grant <= RR_RESET_LAST;
        end else begin
            r_state      <= w_state_nxt;
            r_lock_id    <= w_lock_id_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    ul_rd_tag_fifo #(
        .DEPTH   (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .i_clk   (s_ul_clk),
        .i_rst   (s_ul_rst),
        .i_push  (w_ar_accept),
        .i_din   (w_grant),
        .i_pop   (w_r_pop),
        .o_head  (w_head),
        .o_count (outstanding),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Responses are strictly ordered: a stalled head requester blocks everyone behind it.
    assign m_ul_rready  = !s_ul_rst && !w_empty &&
                          ((w_head == 1'b1) ? s1_ul_rready : s0_ul_rready);
    assign w_r_pop      = m_ul_rvalid && m_ul_rready;
    assign s0_ul_rvalid = !s_ul_rst && !w_empty && (w_head == 1'b0) && m_ul_rvalid;
    assign s1_ul_rvalid = !s_ul_rst && !w_empty && (w_head == 1'b1) && m_ul_rvalid;
    assign s0_ul_rdata  = m_ul_rdata;
    assign s1_ul_rdata  = m_ul_rdata;

endmodule

// File: tb/tb_ul_read_arb_axis.sv
// tb/tb_ul_read_arb_axis.sv - directed self-checking bench for ul_read_arb_axis
module tb_ul_read_arb_axis;

    logic        clk;
    logic        rst;
    logic [3:0]  s0_araddr, s1_araddr, m_araddr;
    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
    logic [31:0] s0_rdata, s1_rdata, m_rdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [3:0]  outstanding;

    int n_vec;
    int n_err;

    ul_read_arb_axis dut (
        .s_ul_clk      (clk),
        .s_ul_rst      (rst),
        .s0_ul_araddr  (s0_araddr),
        .s0_ul_arvalid (s0_arvalid),
        .s0_ul_arready (s0_arready),
        .s0_ul_rdata   (s0_rdata),
        .s0_ul_rvalid  (s0_rvalid),
        .s0_ul_rready  (s0_rready),
        .s1_ul_araddr  (s1_araddr),
        .s1_ul_arvalid (s1_arvalid),
        .s1_ul_arready (s1_arready),
        .s1_ul_rdata   (s1_rdata),
        .s1_ul_rvalid  (s1_rvalid),
        .s1_ul_rready  (s1_rready),
        .m_ul_araddr   (m_araddr),
        .m_ul_arvalid  (m_arvalid),
        .m_ul_arready  (m_arready),
        .m_ul_rdata    (m_rdata),
        .m_ul_rvalid   (m_rvalid),
        .m_ul_rready   (m_rready),
        .outstanding   (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        s0_araddr = 4'h0; s0_arvalid = 1'b0; s0_rready = 1'b0;
        s1_araddr = 4'h0; s1_arvalid = 1'b0; s1_rready = 1'b0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;

        cyc();
        s0_arvalid = 1'b1; s1_arvalid = 1'b1; m_arready = 1'b1; m_rvalid = 1'b1;
        s0_rready = 1'b1; s1_rready = 1'b1;
        #1;
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_s0_arready", s0_arready, 0);
        chk("rst_s1_arready", s1_arready, 0);
        chk("rst_s0_rvalid", s0_rvalid, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_outstanding", outstanding, 0);

        // round robin, both requesting: s0,s1,s0,s1
        cyc();
        rst = 1'b0; m_rvalid = 1'b0;
        s0_araddr = 4'h1; s1_araddr = 4'h2;
        #1;
        chk("rr0_s0_arready", s0_arready, 1);
        chk("rr0_s1_arready", s1_arready, 0);
        chk("rr0_addr", m_araddr, 4'h1);
        cyc(); #1;
        chk("rr1_s1_arready", s1_arready, 1);
        chk("rr1_s0_arready", s0_arready, 0);
        chk("rr1_addr", m_araddr, 4'h2);
        chk("rr1_out", outstanding, 1);
        cyc(); #1;
        chk("rr2_s0_arready", s0_arready, 1);
        chk("rr2_out", outstanding, 2);
        cyc(); #1;
        chk("rr3_s1_arready", s1_arready, 1);
        chk("rr3_out", outstanding, 3);
        cyc();
        s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hD000_0000;
        #1;
        chk("rd0_out", outstanding, 4);
        chk("rd0_s0_rvalid", s0_rvalid, 1);
        chk("rd0_s1_rvalid", s1_rvalid, 0);
        chk("rd0_s0_rdata", s0_rdata, 32'hD000_0000);
        cyc(); m_rdata = 32'hD000_0001; #1;
        chk("rd1_s1_rvalid", s1_rvalid, 1);
        chk("rd1_s0_rvalid", s0_rvalid, 0);
        chk("rd1_s1_rdata", s1_rdata, 32'hD000_0001);
        cyc(); m_rdata = 32'hD000_0002; #1;
        chk("rd2_s0_rvalid", s0_rvalid, 1);
        chk("rd2_s1_rvalid", s1_rvalid, 0);
        cyc(); m_rdata = 32'hD000_0003; #1;
        chk("rd3_s1_rvalid", s1_rvalid, 1);
        chk("rd3_out", outstanding, 1);
        cyc(); m_rvalid = 1'b0; #1;
        chk("rd_done_out", outstanding, 0);

        // single read from s0
        s0_araddr = 4'h3; s0_arvalid = 1'b1; #1;
        chk("sr_m_arvalid", m_arvalid, 1);
        chk("sr_addr", m_araddr, 4'h3);
        chk("sr_s0_arready", s0_arready, 1);
        cyc();
        s0_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hA5A5_0001; #1;
        chk("sr_out1", outstanding, 1);
        chk("sr_s0_rvalid", s0_rvalid, 1);
        chk("sr_s0_rdata", s0_rdata, 32'hA5A5_0001);
        chk("sr_s1_rvalid", s1_rvalid, 0);
        chk("sr_m_rready", m_rready, 1);
        cyc(); m_rvalid = 1'b0; #1;
        chk("sr_out0", outstanding, 0);

        // lock: s0 stalled for 3 cycles, s1 arrives during the stall
        s0_araddr = 4'h5; s0_arvalid = 1'b1; m_arready = 1'b0; #1;
        chk("lk0_addr", m_araddr, 4'h5);
        chk("lk0_s0_arready", s0_arready, 0);
        cyc(); s1_araddr = 4'h9; s1_arvalid = 1'b1; #1;
        chk("lk1_addr", m_araddr, 4'h5);
        chk("lk1_s1_arready", s1_arready, 0);
        cyc(); #1;
        chk("lk2_addr", m_araddr, 4'h5);
        chk("lk2_s1_arready", s1_arready, 0);
        cyc(); m_arready = 1'b1; #1;
        chk("lk3_s0_arready", s0_arready, 1);
        chk("lk3_s1_arready", s1_arready, 0);
        chk("lk3_addr", m_araddr, 4'h5);
        cyc(); #1;
        chk("lk4_s1_arready", s1_arready, 1);
        chk("lk4_s0_arready", s0_arready, 0);
        chk("lk4_addr", m_araddr, 4'h9);

        // head backpressure: drain s0, then stall s1 at the head
        cyc(); s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1111_0000; #1;
        chk("bp0_s0_rvalid", s0_rvalid, 1);
        chk("bp0_out", outstanding, 2);
        cyc(); s1_rready = 1'b0; m_rdata = 32'h1111_0001; #1;
        chk("bp1_m_rready", m_rready, 0);
        chk("bp1_s0_rvalid", s0_rvalid, 0);
        chk("bp1_s1_rvalid", s1_rvalid, 1);
        chk("bp1_out", outstanding, 1);
        cyc(); #1;
        chk("bp2_out", outstanding, 1);
        chk("bp2_m_rready", m_rready, 0);
        s1_rready = 1'b1; #1;
        chk("bp2_rel_m_rready", m_rready, 1);
        cyc(); m_rvalid = 1'b0; #1;
        chk("bp3_out", outstanding, 0);

        // fill the tag FIFO
        s0_arvalid = 1'b1; s0_araddr = 4'h7;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("fill_s0_arready", s0_arready, 1);
            chk("fill_out", outstanding, i);
            cyc();
        end
        #1;
        chk("full_m_arvalid", m_arvalid, 0);
        chk("full_s0_arready", s0_arready, 0);
        chk("full_s1_arready", s1_arready, 0);
        chk("full_out", outstanding, 8);
        m_rvalid = 1'b1; #1;
        chk("full_pop_m_rready", m_rready, 1);
        chk("full_pop_m_arvalid", m_arvalid, 0);
        cyc(); m_rvalid = 1'b0; #1;
        chk("after_pop_out", outstanding, 7);
        chk("after_pop_s0_arready", s0_arready, 1);
        cyc(); #1;
        chk("refill_out", outstanding, 8);

        // reset mid-operation
        rst = 1'b1; s1_arvalid = 1'b1; m_rvalid = 1'b1; #1;
        chk("mrst_m_arvalid", m_arvalid, 0);
        chk("mrst_s0_arready", s0_arready, 0);
        chk("mrst_s1_arready", s1_arready, 0);
        chk("mrst_s0_rvalid", s0_rvalid, 0);
        chk("mrst_s1_rvalid", s1_rvalid, 0);
        chk("mrst_m_rready", m_rready, 0);
        cyc(); rst = 1'b0; #1;
        chk("prst_out", outstanding, 0);
        chk("prst_s0_arready", s0_arready, 1);
        chk("prst_s1_arready", s1_arready, 0);
        chk("prst_empty_m_rready", m_rready, 0);
        chk("prst_empty_s0_rvalid", s0_rvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
